// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: memop encodings, FSM
// state type, access-size type and small decode helpers.
package mem_pkg;

    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LBU = 4'd2,
        MEM_LH  = 4'd3,
        MEM_LHU = 4'd4,
        MEM_LW  = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } memop_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    function automatic logic is_load(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW: is_load = 1'b1;
            default:                                  is_load = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        case (op)
            MEM_SB, MEM_SH, MEM_SW: is_store = 1'b1;
            default:                is_store = 1'b0;
        endcase
    endfunction

    // Non-memory encodings report word size; callers gate with is_load/is_store.
    function automatic size_t size_of(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: size_of = SZ_B;
            MEM_LH, MEM_LHU, MEM_SH: size_of = SZ_H;
            default:                 size_of = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Single-outstanding request/acknowledge data bus.
// master: drives req/we/addr/sel/wdata, receives rdata/ack.
// slave : the memory side.
interface mem_access_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  bus_req_o;
    logic                  bus_we_o;
    logic [ADDR_W-1:0]     bus_addr_o;
    logic [DATA_W/8-1:0]   bus_sel_o;
    logic [DATA_W-1:0]     bus_wdata_o;
    logic [DATA_W-1:0]     bus_rdata_i;
    logic                  bus_ack_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
        input  bus_rdata_i, bus_ack_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
        output bus_rdata_i, bus_ack_i
    );
endinterface

// File: rtl/mem_access_load_align.sv
// load_align: combinational lane select and sign/zero extension of bus read
// data for a load.
// Ports: rdata_i (raw bus word), offset_i (byte offset inside the word),
//        op_i (load kind), data_o (register-ready value).
module load_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]           rdata_i,
    input  logic [$clog2(DATA_W/8)-1:0] offset_i,
    input  memop_t                      op_i,
    output logic [DATA_W-1:0]           data_o
);
    logic [DATA_W-1:0] shifted;

    always_comb begin
        shifted = rdata_i >> {offset_i, 3'b000};
        data_o  = rdata_i;
        case (op_i)
            MEM_LB:  data_o = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
            MEM_LBU: data_o = {{(DATA_W-8){1'b0}}, shifted[7:0]};
            MEM_LH:  data_o = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            MEM_LHU: data_o = {{(DATA_W-16){1'b0}}, shifted[15:0]};
            default: data_o = rdata_i;
        endcase
    end
endmodule

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage. Registers the writeback triple and runs
// loads/stores over a single-outstanding req/ack bus with wait-state stall,
// misalignment exception and bus timeout.
// Ports: clk, rst (async active-low); valid_i/memop_i/mem_addr_i/store_data_i
//        from EX/MEM; wd_i/wreg_i/wdata_i -> wd_o/wreg_o/wdata_o writeback;
//        stallreq_o (combinational) holds upstream; excep_o one-cycle pulse;
//        bus: mem_access_if master modport.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | pass-through; accepts an aligned memory op onto the bus
// BUSY    | bus request outstanding, waiting for ack or timeout
module mem_access
    import mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [3:0]            memop_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [DATA_W-1:0]     store_data_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic                  stallreq_o,
    output logic                  excep_o,
    mem_access_if.master          bus
);
    localparam int SEL_W = DATA_W / 8;
    localparam int OFF_W = $clog2(SEL_W);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    memop_t                  op_q;
    logic [OFF_W-1:0]        off_q;
    logic [REG_ADDR_W-1:0]   wd_q;
    logic                    wreg_q;

    logic                    mem_op_in;
    logic                    misaligned;
    logic                    accept;
    logic                    term_cnt;
    size_t                   sz_in;
    logic [OFF_W-1:0]        off_in;
    logic [SEL_W-1:0]        sel_nxt;
    logic [DATA_W-1:0]       wdata_nxt;
    logic [DATA_W-1:0]       ld_data;

    assign off_in     = mem_addr_i[OFF_W-1:0];
    assign sz_in      = size_of(memop_i);
    assign mem_op_in  = valid_i && (is_load(memop_i) || is_store(memop_i));
    assign misaligned = ((sz_in == SZ_H) && off_in[0]) ||
                        ((sz_in == SZ_W) && (|off_in));
    assign accept     = (state == ST_IDLE) && mem_op_in && !misaligned;
    // Down-counter is loaded with TIMEOUT-1, so zero marks the last wait cycle.
    assign term_cnt   = (cnt == '0);

    // Ack wins over timeout in the terminal cycle.
    assign stallreq_o = accept ||
                        ((state == ST_BUSY) && !bus.bus_ack_i && !term_cnt);

    always_comb begin
        sel_nxt   = '1;
        wdata_nxt = '0;
        case (sz_in)
            SZ_B: begin
                sel_nxt = SEL_W'(1) << off_in;
                for (int i = 0; i < SEL_W; i++)
                    wdata_nxt[i*8 +: 8] = store_data_i[7:0];
            end
            SZ_H: begin
                sel_nxt = SEL_W'(3) << off_in;
                for (int i = 0; i < SEL_W/2; i++)
                    wdata_nxt[i*16 +: 16] = store_data_i[15:0];
            end
            default: begin
                sel_nxt   = '1;
                wdata_nxt = store_data_i;
            end
        endcase
        // Loads leave the write data bus quiet.
        if (!is_store(memop_i))
            wdata_nxt = '0;
    end

    load_align #(.DATA_W(DATA_W)) u_load_align (
        .rdata_i  (bus.bus_rdata_i),
        .offset_i (off_q),
        .op_i     (op_q),
        .data_o   (ld_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            op_q            <= MEM_NOP;
            off_q           <= '0;
            wd_q            <= '0;
            wreg_q          <= 1'b0;
            wd_o            <= '0;
            wreg_o          <= 1'b0;
            wdata_o         <= '0;
            excep_o         <= 1'b0;
            bus.bus_req_o   <= 1'b0;
            bus.bus_we_o    <= 1'b0;
            bus.bus_addr_o  <= '0;
            bus.bus_sel_o   <= '0;
            bus.bus_wdata_o <= '0;
        end else begin
            excep_o <= 1'b0;
            wreg_o  <= 1'b0;
            if (state == ST_IDLE) begin
                wd_o    <= wd_i;
                wdata_o <= wdata_i;
                if (!mem_op_in) begin
                    wreg_o <= valid_i && wreg_i;
                end else if (misaligned) begin
                    excep_o <= 1'b1;
                end else begin
                    state           <= ST_BUSY;
                    cnt             <= CNT_W'(TIMEOUT - 1);
                    op_q            <= memop_t'(memop_i);
                    off_q           <= off_in;
                    wd_q            <= wd_i;
                    wreg_q          <= wreg_i;
                    bus.bus_req_o   <= 1'b1;
                    bus.bus_we_o    <= is_store(memop_i);
                    bus.bus_addr_o  <= {mem_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    bus.bus_sel_o   <= sel_nxt;
                    bus.bus_wdata_o <= wdata_nxt;
                end
            end else begin
                if (bus.bus_ack_i) begin
                    state         <= ST_IDLE;
                    bus.bus_req_o <= 1'b0;
                    bus.bus_we_o  <= 1'b0;
                    wd_o          <= wd_q;
                    if (is_load(op_q)) begin
                        wdata_o <= ld_data;
                        wreg_o  <= wreg_q;
                    end
                end else if (term_cnt) begin
                    state         <= ST_IDLE;
                    bus.bus_req_o <= 1'b0;
                    bus.bus_we_o  <= 1'b0;
                    excep_o       <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Testbench for mem_access: directed cases plus randomized ops checked
// against an instruction-level reference model.
module tb_mem_access;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [3:0]  memop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] store_data_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;
    logic        excep_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    mem_access #(
        .DATA_W(32), .ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT(TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .memop_i      (memop_i),
        .mem_addr_i   (mem_addr_i),
        .store_data_i (store_data_i),
        .wd_i         (wd_i),
        .wreg_i       (wreg_i),
        .wdata_i      (wdata_i),
        .wd_o         (wd_o),
        .wreg_o       (wreg_o),
        .wdata_o      (wdata_o),
        .stallreq_o   (stallreq_o),
        .excep_o      (excep_o),
        .bus          (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One instruction from the EX/MEM slot. ack_at is the BUSY cycle
    // (1-based) carrying the ack; anything above TO means no ack in time.
    task automatic run_op(input bit v, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [4:0] wd, input bit wr,
                          input logic [31:0] wdat, input int ack_at, input logic [31:0] rdata);
        bit ld, st, mem, mis, acked;
        int sz, off;
        logic [31:0] b, h, exp_ld, exp_sel, exp_wdata;

        ld  = (op >= 4'd1 && op <= 4'd5);
        st  = (op >= 4'd6 && op <= 4'd8);
        mem = v && (ld || st);
        sz  = (op == 4'd1 || op == 4'd2 || op == 4'd6) ? 1 :
              (op == 4'd3 || op == 4'd4 || op == 4'd7) ? 2 : 4;
        off = int'(addr % 4);
        mis = mem && (off % sz != 0);

        b = (rdata >> (8 * off)) % 256;
        h = (rdata >> (8 * off)) % 65536;
        case (op)
            4'd1:    exp_ld = (b >= 128) ? b + 32'hFFFF_FF00 : b;
            4'd2:    exp_ld = b;
            4'd3:    exp_ld = (h >= 32768) ? h + 32'hFFFF_0000 : h;
            4'd4:    exp_ld = h;
            default: exp_ld = rdata;
        endcase
        exp_sel   = (sz == 1) ? (32'd1 << off) : (sz == 2) ? (32'd3 << off) : 32'hF;
        exp_wdata = (sz == 1) ? (sdata % 256) * 32'h0101_0101 :
                    (sz == 2) ? (sdata % 65536) * 32'h0001_0001 : sdata;

        valid_i = v; memop_i = op; mem_addr_i = addr; store_data_i = sdata;
        wd_i = wd; wreg_i = wr; wdata_i = wdat;
        bus.bus_ack_i = 1'b0;
        #1;
        check("stall_accept", stallreq_o, mem && !mis);

        if (!mem || mis) begin
            tick();
            valid_i = 1'b0;
            check("bus_req_none", bus.bus_req_o, 1'b0);
            check("excep", excep_o, mis);
            if (mis) begin
                check("wreg_mis", wreg_o, 1'b0);
            end else begin
                check("wd", wd_o, wd);
                check("wreg", wreg_o, v && wr);
                check("wdata", wdata_o, wdat);
            end
            return;
        end

        tick();
        acked = 1'b0;
        for (int j = 1; j <= TO; j++) begin
            bus.bus_ack_i   = (j == ack_at);
            bus.bus_rdata_i = (j == ack_at) ? rdata : $urandom;
            check("bus_req", bus.bus_req_o, 1'b1);
            check("bus_addr", bus.bus_addr_o, addr - off);
            check("bus_sel", bus.bus_sel_o, exp_sel);
            check("bus_we", bus.bus_we_o, st);
            if (st) check("bus_wdata", bus.bus_wdata_o, exp_wdata);
            check("wreg_busy", wreg_o, 1'b0);
            check("excep_busy", excep_o, 1'b0);
            #1;
            check("stall_busy", stallreq_o, (j != ack_at) && (j != TO));
            acked = (j == ack_at);
            tick();
            if (acked) break;
        end
        valid_i = 1'b0;
        bus.bus_ack_i = 1'b0;
        check("bus_req_end", bus.bus_req_o, 1'b0);
        if (acked) begin
            check("excep_ack", excep_o, 1'b0);
            check("wreg_ack", wreg_o, ld && wr);
            if (ld) begin
                check("wd_ld", wd_o, wd);
                check("wdata_ld", wdata_o, exp_ld);
            end
        end else begin
            check("excep_timeout", excep_o, 1'b1);
            check("wreg_timeout", wreg_o, 1'b0);
            // A late ack while idle must not start or complete anything.
            bus.bus_ack_i = 1'b1;
            tick();
            bus.bus_ack_i = 1'b0;
            check("late_ack_req", bus.bus_req_o, 1'b0);
            check("late_ack_excep", excep_o, 1'b0);
            check("late_ack_wreg", wreg_o, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b0;
        valid_i = 1'b0; memop_i = 4'd0; mem_addr_i = '0; store_data_i = '0;
        wd_i = '0; wreg_i = 1'b0; wdata_i = '0;
        bus.bus_ack_i = 1'b0; bus.bus_rdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wd", wd_o, 0);
        check("rst_wreg", wreg_o, 0);
        check("rst_wdata", wdata_o, 0);
        check("rst_stall", stallreq_o, 0);
        check("rst_excep", excep_o, 0);
        check("rst_req", bus.bus_req_o, 0);
        check("rst_sel", bus.bus_sel_o, 0);
        check("rst_addr", bus.bus_addr_o, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // ALU pass-through, LB/LBU with two wait cycles, SH immediate ack,
        // misaligned LW, LW timeout with a late ack.
        run_op(1, 4'd0, 32'h0,   32'h0,         5'd5, 1, 32'h1234, 0, 32'h0);
        run_op(1, 4'd1, 32'h103, 32'h0,         5'd7, 1, 32'h0,    2, 32'h80FF_0000);
        run_op(1, 4'd2, 32'h103, 32'h0,         5'd7, 1, 32'h0,    2, 32'h80FF_0000);
        run_op(1, 4'd7, 32'h202, 32'hABCD_1234, 5'd3, 1, 32'h0,    1, 32'h0);
        run_op(1, 4'd5, 32'h101, 32'h0,         5'd4, 1, 32'h0,    1, 32'h0);
        run_op(1, 4'd5, 32'h300, 32'h0,         5'd9, 1, 32'h0,    TO + 1, 32'h0);

        // Reset during BUSY abandons the transfer.
        valid_i = 1'b1; memop_i = 4'd5; mem_addr_i = 32'h40; wd_i = 5'd2; wreg_i = 1'b1;
        tick();
        check("pre_rst_req", bus.bus_req_o, 1'b1);
        rst = 1'b0;
        valid_i = 1'b0;
        #1;
        check("mid_rst_req", bus.bus_req_o, 0);
        check("mid_rst_wreg", wreg_o, 0);
        check("mid_rst_wd", wd_o, 0);
        check("mid_rst_wdata", wdata_o, 0);
        check("mid_rst_excep", excep_o, 0);
        check("mid_rst_sel", bus.bus_sel_o, 0);
        check("mid_rst_stall", stallreq_o, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        run_op(1, 4'd5, 32'h40, 32'h0, 5'd2, 1, 32'h0, 1, 32'hDEAD_BEEF);

        for (int n = 0; n < 80; n++) begin
            run_op($urandom_range(0, 9) != 0, 4'($urandom_range(0, 8)),
                   {22'd0, 8'($urandom), 2'($urandom)}, $urandom,
                   5'($urandom), 1'($urandom), $urandom,
                   $urandom_range(1, TO + 1), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access.md
# mem_access

Parametrised successor to the pass-through memory stage of the ToruMIPS pipeline. It sits between the EX/MEM register and the MEM/WB boundary and registers the writeback triple. It also performs loads and stores through a single-outstanding request/acknowledge data bus, handling byte, halfword and word access with sign/zero extension. It stalls the pipeline for wait states, flags misaligned accesses, and aborts bus cycles that exceed a timeout.

## Interface
- DATA_W, 32, data/register width (multiple of 8)
- ADDR_W, 32, bus address width
- REG_ADDR_W, 5, register-file address width
- TIMEOUT, 255, maximum wait cycles before abort (≥1)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- valid_i  in  1  EX/MEM slot holds an instruction
- memop_i  in  4  MEM_NOP, LB, LBU, LH, LHU, LW, SB, SH, SW (encodings in package)
- mem_addr_i  in  ADDR_W  effective address
- store_data_i  in  DATA_W  rt value for stores
- wd_i / wreg_i / wdata_i  in  REG_ADDR_W / 1 / DATA_W  writeback destination, enable, ALU result
- wd_o / wreg_o / wdata_o  out  REG_ADDR_W / 1 / DATA_W  registered writeback
- stallreq_o  out  1  hold EX/MEM and earlier stages
- excep_o  out  1  one-cycle pulse: misaligned access or bus timeout
- bus_req_o, bus_we_o  out  1 each  request, write strobe
- bus_addr_o  out  ADDR_W  word-aligned address (low log2(DATA_W/8) bits zero)
- bus_sel_o  out  DATA_W/8  byte enables
- bus_wdata_o  out  DATA_W  lane-replicated store data
- bus_rdata_i  in  DATA_W  read data, valid with ack
- bus_ack_i  in  1  transfer complete

## Operation
- FSM states: IDLE, BUSY.
- IDLE, valid_i=0 or MEM_NOP: register wd_i/wreg_i/wdata_i to outputs next edge; wreg_o=0 when valid_i=0.
- IDLE, memory op, misaligned (halfword addr[0]≠0, word addr[1:0]≠0): no bus cycle; excep_o=1 and wreg_o=0 next edge; no stall.
- IDLE, aligned memory op: capture destination, op, byte offset; drive bus_* registered; enter BUSY; reset wait counter.
- BUSY: bus_req_o and all bus_* held constant until ack or timeout.
- BUSY, bus_ack_i=1: return to IDLE.
  - Load: wdata_o = lane-selected rdata, sign-extended (LB/LH) or zero-extended (LBU/LHU); wreg_o=wreg_i captured.
  - Store: wreg_o=0.
- BUSY, counter reaches TIMEOUT without ack: drop req, excep_o pulse, wreg_o=0, return to IDLE.
- Byte lanes are little-endian: SB sel = 1<<addr[1:0], SH sel = 0b11<<addr[1:0], SW sel all ones. Store data is replicated into every lane of its size.
- stallreq_o = (IDLE ∧ valid_i ∧ aligned mem op) ∨ (BUSY ∧ ¬bus_ack_i ∧ ¬timeout). It is combinational; upstream holds inputs while it is high.
- A bus_ack_i in IDLE is ignored.

## Timing
- Reset (async assert, sync-safe release): state IDLE; wd_o=0, wreg_o=0, wdata_o=0, stallreq_o=0, excep_o=0, bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_sel_o=0, bus_wdata_o=0, counter=0.
- Reset mid-BUSY drops bus_req_o immediately; the transaction is abandoned with no writeback.
- Non-memory op: 1-cycle latency, zero stall.
- Memory op accepted at cycle t: bus_req_o high from t+1. If ack is sampled at cycle k ≥ t+1, the writeback is visible at k+1 and stall cycles = k−t.
- Timeout: with no ack through cycle t+TIMEOUT, req drops and excep_o is visible at t+TIMEOUT+1.
- Ack and timeout in the same cycle: ack wins.
- excep_o and wreg_o are never both high.

## Structure
- Shared package `mem_pkg`:
  - memop encodings (MEM_NOP=0, LB, LBU, LH, LHU, LW, SB, SH, SW)
  - state enum
  - functions is_load, is_store, size_of
- Sub-module `load_align`: combinational lane select plus extension from rdata, offset and op. Reused by a future cache.
- Store lane/sel generation stays inline.

## Test plan
- ALU op, valid_i=1, wd_i=5, wdata_i=0x1234 → next cycle wd_o=5, wreg_o=1, wdata_o=0x1234, stallreq_o never high.
- LB addr=0x103, rdata=0x80FF_0000, ack on 2nd BUSY cycle → bus_sel_o=4'b1000, stall for 2 cycles, wdata_o=0xFFFF_FF80; repeat with LBU → 0x0000_0080.
- SH addr=0x202, store_data=0xABCD_1234, ack immediate → bus_addr_o=0x200, sel=4'b1100, bus_wdata_o=0x1234_1234, bus_we_o=1, wreg_o=0.
- LW addr=0x101 → no bus_req_o, excep_o pulse one cycle, wreg_o=0, stallreq_o low.
- TIMEOUT=4, LW with ack never asserted → req high 4 cycles then low, excep_o pulse; a late ack in IDLE is ignored.
- Assert rst mid-BUSY → bus_req_o low asynchronously, all outputs zero; after release a new LW completes normally.
